// File: rtl/serial_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_cmd_pkg                                                  |
// | Purpose  : Shared definitions for the serial command receiver: ASCII       |
// |            control characters, parser state encoding and the digit-limit   |
// |            derivation used by the value width.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package serial_cmd_pkg;

    localparam logic [7:0] c_ascii_cr = 8'h0D;
    localparam logic [7:0] c_ascii_lf = 8'h0A;
    localparam logic [7:0] c_ascii_sp = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARG     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // One hex digit carries four bits of the value.
    function automatic int f_max_digits(input int value_width);
        return value_width / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_hex_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_hex_decode                                               |
// | Purpose  : Combinational ASCII classifier for the command parser.          |
// | Ports    : i_byte      in  8  received character                           |
// |            o_is_hex    out 1  character is 0-9, A-F or a-f                 |
// |            o_is_letter out 1  character is A-Z or a-z                      |
// |            o_nibble    out 4  hex value of the character (0 if not hex)    |
// |            o_upper     out 8  character folded to upper case               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module serial_hex_decode (
    input  logic [7:0] i_byte,
    output logic       o_is_hex,
    output logic       o_is_letter,
    output logic [3:0] o_nibble,
    output logic [7:0] o_upper
);

    logic w_is_digit;
    logic w_is_upper;
    logic w_is_lower;

    always_comb begin
        w_is_digit  = (i_byte >= 8'h30) && (i_byte <= 8'h39);
        w_is_upper  = (i_byte >= 8'h41) && (i_byte <= 8'h5A);
        w_is_lower  = (i_byte >= 8'h61) && (i_byte <= 8'h7A);
        o_is_letter = w_is_upper || w_is_lower;
        o_upper     = w_is_lower ? (i_byte - 8'h20) : i_byte;
        o_is_hex    = 1'b0;
        o_nibble    = 4'h0;
        if (w_is_digit) begin
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0];
        end else if (((i_byte >= 8'h41) && (i_byte <= 8'h46)) ||
                     ((i_byte >= 8'h61) && (i_byte <= 8'h66))) begin
            // 'A'/'a' have low nibble 1, so adding 9 gives 10..15.
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0] + 4'd9;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_cmd_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_cmd_receiver                                             |
// | Purpose  : Parses "<letter><hex digits><CR|LF>" lines from the USB-serial  |
// |            receive stream into a command code and value, presented on a    |
// |            valid/ready handshake, with one-cycle error pulses for syntax,  |
// |            digit overflow and mid-line timeout.                            |
// | Ports    : clk_48mhz      in  1   system clock                             |
// |            reset_n        in  1   asynchronous active-low reset            |
// |            uart_out_data  in  8   received byte                            |
// |            uart_out_valid in  1   received byte valid                      |
// |            uart_out_ready out 1   byte accepted on valid & ready           |
// |            cmd_code       out 8   command letter, upper case               |
// |            cmd_value      out VW  hex argument, right-aligned              |
// |            cmd_valid      out 1   command available until cmd_ready       |
// |            cmd_ready      in  1   application accepts command              |
// |            err_syntax     out 1   pulse: illegal character                 |
// |            err_overflow   out 1   pulse: too many digits                   |
// |            err_timeout    out 1   pulse: partial line abandoned            |
// |            echo_data      out 8   (SERIAL_ECHO_EN) copy of accepted byte   |
// |            echo_valid     out 1   (SERIAL_ECHO_EN) echo byte available     |
// |            echo_ready     in  1   (SERIAL_ECHO_EN) echo consumer ready     |
// | Config   : define SERIAL_ECHO_EN to add the one-entry echo register.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module serial_cmd_receiver
    import serial_cmd_pkg::*;
#(
    parameter int VALUE_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 48_000_000
) (
    input  logic                   clk_48mhz,
    input  logic                   reset_n,
    input  logic [7:0]             uart_out_data,
    input  logic                   uart_out_valid,
    output logic                   uart_out_ready,
    output logic [7:0]             cmd_code,
    output logic [VALUE_WIDTH-1:0] cmd_value,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   err_syntax,
    output logic                   err_overflow,
    output logic                   err_timeout
`ifdef SERIAL_ECHO_EN
    ,
    output logic [7:0]             echo_data,
    output logic                   echo_valid,
    input  logic                   echo_ready
`endif
);

    localparam int c_max_digits = f_max_digits(VALUE_WIDTH);
    localparam int c_ndig_w     = $clog2(c_max_digits + 1);
    localparam bit c_tmo_en     = (TIMEOUT_CYCLES != 0);
    localparam int c_tmo_w      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_ndig_w-1:0] c_ndig_max = c_ndig_w'(c_max_digits);
    localparam logic [c_ndig_w-1:0] c_ndig_one = c_ndig_w'(1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_en ? c_tmo_w'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [c_tmo_w-1:0]  c_tmo_one  = c_tmo_w'(1);

    state_t                 r_state,     w_state_nxt;
    logic [7:0]             r_code,      w_code_nxt;
    logic [VALUE_WIDTH-1:0] r_value,     w_value_nxt;
    logic [c_ndig_w-1:0]    r_ndig,      w_ndig_nxt;
    logic [c_tmo_w-1:0]     r_tmo_cnt,   w_tmo_nxt;
    logic                   r_cmd_valid, w_cmd_valid_nxt;
    logic [7:0]             r_cmd_code,  w_cmd_code_nxt;
    logic [VALUE_WIDTH-1:0] r_cmd_value, w_cmd_value_nxt;
    logic                   r_err_syn,   w_err_syn_nxt;
    logic                   r_err_ovf,   w_err_ovf_nxt;
    logic                   r_err_tmo,   w_err_tmo_nxt;

    logic       w_ready;
    logic       w_accept;
    logic       w_is_term;
    logic       w_is_hex;
    logic       w_is_letter;
    logic [3:0] w_nibble;
    logic [7:0] w_upper;

    serial_hex_decode u_hex_decode (
        .i_byte      (uart_out_data),
        .o_is_hex    (w_is_hex),
        .o_is_letter (w_is_letter),
        .o_nibble    (w_nibble),
        .o_upper     (w_upper)
    );

    assign w_is_term = (uart_out_data == c_ascii_cr) || (uart_out_data == c_ascii_lf);
    assign w_accept  = uart_out_valid && w_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_value_nxt     = r_value;
        w_ndig_nxt      = r_ndig;
        w_tmo_nxt       = r_tmo_cnt;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_code_nxt  = r_cmd_code;
        w_cmd_value_nxt = r_cmd_value;
        w_err_syn_nxt   = 1'b0;
        w_err_ovf_nxt   = 1'b0;
        w_err_tmo_nxt   = 1'b0;

        // Input is stalled while a command is pending, so this clear can
        // never coincide with a terminator setting cmd_valid.
        if (r_cmd_valid && cmd_ready) begin
            w_cmd_valid_nxt = 1'b0;
        end

        if (w_accept) begin
            w_tmo_nxt = '0;
            if (uart_out_data != c_ascii_sp) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_letter) begin
                            w_code_nxt  = w_upper;
                            w_value_nxt = '0;
                            w_ndig_nxt  = '0;
                            w_state_nxt = S_ARG;
                        end else if (!w_is_term) begin
                            w_err_syn_nxt = 1'b1;
                            w_state_nxt   = S_DISCARD;
                        end
                    end
                    S_ARG: begin
                        if (w_is_hex) begin
                            if (r_ndig == c_ndig_max) begin
                                w_err_ovf_nxt = 1'b1;
                                w_state_nxt   = S_DISCARD;
                            end else begin
                                w_value_nxt = (r_value << 4) | VALUE_WIDTH'(w_nibble);
                                w_ndig_nxt  = r_ndig + c_ndig_one;
                            end
                        end else if (w_is_term) begin
                            w_cmd_valid_nxt = 1'b1;
                            w_cmd_code_nxt  = r_code;
                            w_cmd_value_nxt = r_value;
                            w_state_nxt     = S_IDLE;
                        end else begin
                            w_err_syn_nxt = 1'b1;
                            w_state_nxt   = S_DISCARD;
                        end
                    end
                    S_DISCARD: begin
                        if (w_is_term) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end else if (r_state == S_IDLE) begin
            w_tmo_nxt = '0;
        end else if (c_tmo_en) begin
            // Reaching the last count abandons the line; returning to idle
            // clears the counter so it never wraps.
            if (r_tmo_cnt == c_tmo_last) begin
                w_err_tmo_nxt = 1'b1;
                w_state_nxt   = S_IDLE;
                w_tmo_nxt     = '0;
            end else begin
                w_tmo_nxt = r_tmo_cnt + c_tmo_one;
            end
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_code      <= '0;
            r_value     <= '0;
            r_ndig      <= '0;
            r_tmo_cnt   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_value <= '0;
            r_err_syn   <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_value     <= w_value_nxt;
            r_ndig      <= w_ndig_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_code  <= w_cmd_code_nxt;
            r_cmd_value <= w_cmd_value_nxt;
            r_err_syn   <= w_err_syn_nxt;
            r_err_ovf   <= w_err_ovf_nxt;
            r_err_tmo   <= w_err_tmo_nxt;
        end
    end

`ifdef SERIAL_ECHO_EN
    logic [7:0] r_echo_data;
    logic       r_echo_valid;

    // Accept requires an empty echo slot, so load and drain never collide.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_echo_data  <= '0;
            r_echo_valid <= 1'b0;
        end else if (w_accept) begin
            r_echo_data  <= uart_out_data;
            r_echo_valid <= 1'b1;
        end else if (echo_ready) begin
            r_echo_valid <= 1'b0;
        end
    end

    assign echo_data  = r_echo_data;
    assign echo_valid = r_echo_valid;
    assign w_ready    = !r_cmd_valid && !r_echo_valid;
`else
    assign w_ready    = !r_cmd_valid;
`endif

    assign uart_out_ready = w_ready;
    assign cmd_valid      = r_cmd_valid;
    assign cmd_code       = r_cmd_code;
    assign cmd_value      = r_cmd_value;
    assign err_syntax     = r_err_syn;
    assign err_overflow   = r_err_ovf;
    assign err_timeout    = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_cmd_receiver                                          |
// | Purpose  : Self-checking bench for serial_cmd_receiver. A line-level       |
// |            reference model (current line kept as a character array and     |
// |            judged as a whole prefix) predicts every output each cycle;     |
// |            directed scenarios add literal expectations, followed by        |
// |            randomized command lines. Honours SERIAL_ECHO_EN.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_serial_cmd_receiver;

    localparam int c_vw   = 16;
    localparam int c_tmo  = 100;
    localparam int c_maxd = c_vw / 4;

    logic              clk_48mhz      = 1'b0;
    logic              reset_n        = 1'b0;
    logic [7:0]        uart_out_data  = 8'h00;
    logic              uart_out_valid = 1'b0;
    logic              uart_out_ready;
    logic [7:0]        cmd_code;
    logic [c_vw-1:0]   cmd_value;
    logic              cmd_valid;
    logic              cmd_ready      = 1'b1;
    logic              err_syntax;
    logic              err_overflow;
    logic              err_timeout;
`ifdef SERIAL_ECHO_EN
    logic [7:0]        echo_data;
    logic              echo_valid;
    logic              echo_ready     = 1'b1;
`endif

    serial_cmd_receiver #(
        .VALUE_WIDTH    (c_vw),
        .TIMEOUT_CYCLES (c_tmo)
    ) dut (
        .clk_48mhz      (clk_48mhz),
        .reset_n        (reset_n),
        .uart_out_data  (uart_out_data),
        .uart_out_valid (uart_out_valid),
        .uart_out_ready (uart_out_ready),
        .cmd_code       (cmd_code),
        .cmd_value      (cmd_value),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .err_syntax     (err_syntax),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout)
`ifdef SERIAL_ECHO_EN
        ,
        .echo_data      (echo_data),
        .echo_valid     (echo_valid),
        .echo_ready     (echo_ready)
`endif
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int n_vec = 0;
    int n_err = 0;
    bit rand_mode = 1'b0;

    // ---------------- reference model ----------------
    logic [7:0]      m_line [0:63];
    int              m_len  = 0;
    int              m_idle = 0;
    logic            m_cmd_valid = 1'b0;
    logic [7:0]      m_code      = 8'h00;
    logic [c_vw-1:0] m_value     = '0;
    logic            m_err_syn   = 1'b0;
    logic            m_err_ovf   = 1'b0;
    logic            m_err_tmo   = 1'b0;
`ifdef SERIAL_ECHO_EN
    logic            m_echo_valid = 1'b0;
    logic [7:0]      m_echo_data  = 8'h00;
`endif

    function automatic bit is_letter(input logic [7:0] b);
        return (b >= "A" && b <= "Z") || (b >= "a" && b <= "z");
    endfunction

    function automatic bit is_hexc(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic int hexval(input logic [7:0] b);
        if (b <= "9") return int'(b) - 48;
        if (b <= "F") return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    // A line prefix is legal when it is empty, or a letter followed by at
    // most c_maxd hex digits.
    function automatic bit line_ok();
        if (m_len == 0) return 1'b1;
        if (m_len - 1 > c_maxd) return 1'b0;
        if (!is_letter(m_line[0])) return 1'b0;
        for (int i = 1; i < m_len; i++) begin
            if (!is_hexc(m_line[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit m_ready();
`ifdef SERIAL_ECHO_EN
        return !m_cmd_valid && !m_echo_valid;
`else
        return !m_cmd_valid;
`endif
    endfunction

    task automatic model_reset();
        m_len = 0; m_idle = 0;
        m_cmd_valid = 1'b0; m_code = 8'h00; m_value = '0;
        m_err_syn = 1'b0; m_err_ovf = 1'b0; m_err_tmo = 1'b0;
`ifdef SERIAL_ECHO_EN
        m_echo_valid = 1'b0; m_echo_data = 8'h00;
`endif
    endtask

    // Applies the clock edge that has just happened, using the inputs that
    // were held across it.
    task automatic model_step();
        bit         acc;
        bit         ok_before;
        logic [7:0] b;
        int         v;
        acc = uart_out_valid && m_ready();
        m_err_syn = 1'b0; m_err_ovf = 1'b0; m_err_tmo = 1'b0;
        if (m_cmd_valid && cmd_ready) m_cmd_valid = 1'b0;
`ifdef SERIAL_ECHO_EN
        if (acc) begin
            m_echo_valid = 1'b1;
            m_echo_data  = uart_out_data;
        end else if (echo_ready) begin
            m_echo_valid = 1'b0;
        end
`endif
        if (acc) begin
            b = uart_out_data;
            m_idle = 0;
            if (b == 8'h0D || b == 8'h0A) begin
                if (m_len > 0 && line_ok()) begin
                    v = 0;
                    for (int i = 1; i < m_len; i++) v = v * 16 + hexval(m_line[i]);
                    m_cmd_valid = 1'b1;
                    m_code  = (m_line[0] >= "a") ? m_line[0] - 8'd32 : m_line[0];
                    m_value = c_vw'(v);
                end
                m_len = 0;
            end else if (b != 8'h20) begin
                ok_before = line_ok();
                if (m_len < 64) m_line[m_len] = b;
                m_len++;
                if (ok_before && !line_ok()) begin
                    if (is_hexc(b) && (m_len - 1 > c_maxd)) m_err_ovf = 1'b1;
                    else m_err_syn = 1'b1;
                end
            end
        end else if (m_len > 0) begin
            m_idle++;
            if (m_idle == c_tmo) begin
                m_err_tmo = 1'b1;
                m_len  = 0;
                m_idle = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("uart_out_ready", 32'(uart_out_ready), 32'(m_ready()));
        check("cmd_valid",      32'(cmd_valid),      32'(m_cmd_valid));
        if (m_cmd_valid) begin
            check("cmd_code",  32'(cmd_code),  32'(m_code));
            check("cmd_value", 32'(cmd_value), 32'(m_value));
        end
        check("err_syntax",   32'(err_syntax),   32'(m_err_syn));
        check("err_overflow", 32'(err_overflow), 32'(m_err_ovf));
        check("err_timeout",  32'(err_timeout),  32'(m_err_tmo));
`ifdef SERIAL_ECHO_EN
        check("echo_valid", 32'(echo_valid), 32'(m_echo_valid));
        if (m_echo_valid) check("echo_data", 32'(echo_data), 32'(m_echo_data));
`endif
    endtask

    task automatic tick();
        @(negedge clk_48mhz);
        if (!reset_n) model_reset();
        else model_step();
        compare();
        if (rand_mode) begin
            cmd_ready = ($urandom_range(0, 99) < 50);
`ifdef SERIAL_ECHO_EN
            echo_ready = ($urandom_range(0, 99) < 70);
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        uart_out_valid = 1'b1;
        uart_out_data  = b;
        t = 0;
        while (!uart_out_ready && t < 2000) begin
            tick();
            t++;
        end
        n_vec++;
        if (t >= 2000) begin
            n_err++;
            $display("FAIL send_stall: uart_out_ready stayed 0 for %0d cycles, expected 1", t);
        end
        tick();
        uart_out_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    function automatic logic [7:0] rand_letter();
        logic [7:0] base;
        base = ($urandom_range(0, 1) != 0) ? 8'h61 : 8'h41;
        return base + 8'($urandom_range(0, 25));
    endfunction

    function automatic logic [7:0] rand_hex();
        int n;
        n = int'($urandom_range(0, 15));
        if (n < 10) return 8'(48 + n);
        return ($urandom_range(0, 1) != 0) ? 8'(87 + n) : 8'(55 + n);
    endfunction

    initial begin
        logic [7:0] q[$];
        int         kind;
        int         nd;
        string      s;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("reset_cmd_valid", 32'(cmd_valid), 0);
        check("reset_ready",     32'(uart_out_ready), 1);

        // 1: command held while the application stalls
        cmd_ready = 1'b0;
        send_str("L1F\r");
        check("t1_valid", 32'(cmd_valid), 1);
        check("t1_code",  32'(cmd_code), 'h4C);
        check("t1_value", 32'(cmd_value), 'h001F);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_hold_value", 32'(cmd_value), 'h001F);
            check("t1_hold_ready", 32'(uart_out_ready), 0);
        end
        cmd_ready = 1'b1;
        tick();
        check("t1_release_valid", 32'(cmd_valid), 0);
        check("t1_release_ready", 32'(uart_out_ready), 1);

        // 2: fifth digit overflows, then a no-digit command
        send_str("l1234");
        send_byte("5");
        check("t2_overflow", 32'(err_overflow), 1);
        send_byte(8'h0A);
        check("t2_no_cmd", 32'(cmd_valid), 0);
        send_str("x\n");
        check("t2_valid", 32'(cmd_valid), 1);
        check("t2_code",  32'(cmd_code), 'h58);
        check("t2_value", 32'(cmd_value), 0);

        // 3: illegal character, then bare terminators
        send_str("LZ");
        check("t3_syntax", 32'(err_syntax), 1);
        send_byte(8'h0D);
        s = "\r\n\r\n";
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            check("t3_empty_cmd", 32'(cmd_valid), 0);
            check("t3_empty_err", 32'(err_syntax | err_overflow | err_timeout), 0);
        end

        // 4: timeout after exactly c_tmo idle cycles
        send_str("L1");
        repeat (c_tmo - 1) tick();
        check("t4_before", 32'(err_timeout), 0);
        tick();
        check("t4_timeout", 32'(err_timeout), 1);
        tick();
        check("t4_pulse_end", 32'(err_timeout), 0);
        send_byte("2");
        check("t4_syntax", 32'(err_syntax), 1);
        send_byte(8'h0D);
        check("t4_no_cmd", 32'(cmd_valid), 0);

        // 5: asynchronous reset with a pending command and mid-line
        cmd_ready = 1'b0;
        send_str("Q7\r");
        check("t5_pending", 32'(cmd_value), 7);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst_valid", 32'(cmd_valid), 0);
        check("t5_rst_code",  32'(cmd_code), 0);
        check("t5_rst_value", 32'(cmd_value), 0);
        check("t5_rst_err",   32'(err_syntax | err_overflow | err_timeout), 0);
        tick();
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        send_str("L12");
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst2_valid", 32'(cmd_valid), 0);
        tick();
        reset_n = 1'b1;
        send_byte("3");
        check("t5_syntax", 32'(err_syntax), 1);
        send_byte(8'h0D);
        check("t5_no_cmd", 32'(cmd_valid), 0);

`ifdef SERIAL_ECHO_EN
        // 6: echo slot back-pressures the input
        echo_ready = 1'b0;
        send_byte("A");
        check("t6_echo_valid", 32'(echo_valid), 1);
        check("t6_echo_a",     32'(echo_data), 'h41);
        check("t6_stall",      32'(uart_out_ready), 0);
        uart_out_valid = 1'b1;
        uart_out_data  = "B";
        tick();
        tick();
        check("t6_stall_b", 32'(uart_out_ready), 0);
        echo_ready = 1'b1;
        tick();
        check("t6_ready_b", 32'(uart_out_ready), 1);
        tick();
        uart_out_valid = 1'b0;
        check("t6_echo_b", 32'(echo_data), 'h42);
        send_byte(8'h0D);
`endif

        // Randomized command lines
        rand_mode = 1'b1;
        for (int ln = 0; ln < 250; ln++) begin
            q.delete();
            kind = int'($urandom_range(0, 9));
            if (kind <= 4 || kind == 5) begin
                q.push_back(rand_letter());
                nd = (kind == 5) ? int'($urandom_range(c_maxd + 1, c_maxd + 3))
                                 : int'($urandom_range(0, c_maxd));
                for (int d = 0; d < nd; d++) begin
                    if ($urandom_range(0, 7) == 0) q.push_back(8'h20);
                    q.push_back(rand_hex());
                end
            end else if (kind == 6) begin
                q.push_back(rand_letter());
                q.push_back(rand_hex());
                q.push_back(8'($urandom_range(33, 126)));
                q.push_back(rand_hex());
            end else if (kind == 8) begin
                nd = int'($urandom_range(1, 4));
                for (int d = 0; d < nd; d++) q.push_back(8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 1) != 0) q.push_back(8'h0D);
            q.push_back(8'h0A);
            foreach (q[i]) begin
                if ($urandom_range(0, 39) == 0) repeat (c_tmo - 2 + int'($urandom_range(0, 6))) tick();
                else repeat (int'($urandom_range(0, 2))) tick();
                send_byte(q[i]);
            end
        end
        rand_mode = 1'b0;
        cmd_ready = 1'b1;
`ifdef SERIAL_ECHO_EN
        echo_ready = 1'b1;
`endif
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
